// File: rtl/acc_io_port_pkg.sv
// Shared constants for the accumulator CPU I/O port: default word width,
// the memory-mapped I/O address and the IOStatus bit positions.
package acc_io_port_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Address the memory block decodes to raise IOWrite / IORead.
  localparam logic [15:0] IO_ADDR = 16'hFFFE;

  // Bit positions inside IOStatus.
  localparam int IOSTAT_TXFULL  = 0;
  localparam int IOSTAT_RXAVAIL = 1;
  localparam int IOSTAT_TXOVF   = 2;
  localparam int IOSTAT_RXUNF   = 3;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a combinational head read. Callers gate push/pop so
// that a push only happens when there is room (or a pop in the same cycle)
// and a pop only happens when the FIFO holds data.
module io_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word storage.
  // NOTE: storage deliberately has no reset; emptiness is tracked by count,
  // so stale contents are never observable and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW + 1)'(DEPTH));

endmodule

// File: rtl/acc_io_port.sv
// Peripheral endpoint of the accumulator CPU's memory-mapped I/O. CPU stores
// land in a TX FIFO drained to a device over valid/ready; device words land
// in an RX FIFO read back by CPU loads. Sticky error flags and occupancy are
// reported on IOStatus, all derived from registered state.
module acc_io_port
  import acc_io_port_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] IOOut,
  input  logic                  IOWrite,
  input  logic                  IORead,
  output logic [DATA_WIDTH-1:0] IOIn,
  output logic [DATA_WIDTH-1:0] DevOutData,
  output logic                  DevOutValid,
  input  logic                  DevOutReady,
  input  logic [DATA_WIDTH-1:0] DevInData,
  input  logic                  DevInValid,
  output logic                  DevInReady,
  input  logic                  ClearFlags,
  output logic [3:0]            IOStatus
);

  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_empty;
  logic                  tx_full;
  logic [DATA_WIDTH-1:0] tx_head;

  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_empty;
  logic                  rx_full;
  logic [DATA_WIDTH-1:0] rx_head;

  logic                  tx_ovf;
  logic                  rx_unf;
  logic                  tx_ovf_set;
  logic                  rx_unf_set;

  // TX handshake gating: a store into a full FIFO still fits when the head
  // leaves in the same cycle; an empty FIFO has no head to hand over.
  assign tx_pop     = !tx_empty && DevOutReady;
  assign tx_push    = IOWrite && (!tx_full || tx_pop);
  assign tx_ovf_set = IOWrite && tx_full && !tx_pop;

  // RX handshake gating: ready comes only from the registered full state.
  assign rx_push    = DevInValid && !rx_full;
  assign rx_pop     = IORead && !rx_empty;
  assign rx_unf_set = IORead && rx_empty;

  io_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (IOOut),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  io_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (DevInData),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_ovf_set)      tx_ovf <= 1'b1;
      else if (ClearFlags) tx_ovf <= 1'b0;

      if (rx_unf_set)      rx_unf <= 1'b1;
      else if (ClearFlags) rx_unf <= 1'b0;
    end
  end

  // Device-facing and CPU-facing outputs; an empty RX FIFO reads as zero.
  always_comb begin
    DevOutData  = tx_head;
    DevOutValid = !tx_empty;
    DevInReady  = !rx_full;
    IOIn        = rx_empty ? '0 : rx_head;
    IOStatus                 = '0;
    IOStatus[IOSTAT_TXFULL]  = tx_full;
    IOStatus[IOSTAT_RXAVAIL] = !rx_empty;
    IOStatus[IOSTAT_TXOVF]   = tx_ovf;
    IOStatus[IOSTAT_RXUNF]   = rx_unf;
  end

endmodule

// File: tb/tb_acc_io_port.sv
// Scoreboard bench for acc_io_port. The stimulus process keeps a queue-level
// reference of both FIFOs and the flags, pushing expected device words and
// expected load data into queues; a negedge monitor pops and compares them
// whenever the DUT presents a transfer, and checks the status outputs.
module tb_acc_io_port;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [DW-1:0] IOOut = '0;
  logic          IOWrite = 1'b0;
  logic          IORead = 1'b0;
  logic [DW-1:0] IOIn;
  logic [DW-1:0] DevOutData;
  logic          DevOutValid;
  logic          DevOutReady = 1'b0;
  logic [DW-1:0] DevInData = '0;
  logic          DevInValid = 1'b0;
  logic          DevInReady;
  logic          ClearFlags = 1'b0;
  logic [3:0]    IOStatus;

  acc_io_port #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .IOOut       (IOOut),
    .IOWrite     (IOWrite),
    .IORead      (IORead),
    .IOIn        (IOIn),
    .DevOutData  (DevOutData),
    .DevOutValid (DevOutValid),
    .DevOutReady (DevOutReady),
    .DevInData   (DevInData),
    .DevInValid  (DevInValid),
    .DevInReady  (DevInReady),
    .ClearFlags  (ClearFlags),
    .IOStatus    (IOStatus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference state: contents of each FIFO and the two sticky flags.
  logic [DW-1:0] tx_exp[$];   // words the device must see, in order
  int            tx_cnt = 0;
  logic [DW-1:0] rx_q[$];     // words held for the CPU
  logic [DW-1:0] rx_exp[$];   // expected IOIn for each IORead issued
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            last_rx_acc = 1'b0;

  // Expected outputs for the current cycle.
  logic [3:0]    exp_status = 4'b0000;
  logic          exp_ovalid = 1'b0;
  logic          exp_iready = 1'b1;
  logic [DW-1:0] exp_ioin   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, publish the expected outputs for this cycle,
  // then advance the reference to the next cycle.
  task automatic drive(input bit wr, input logic [DW-1:0] wdata, input bit rd,
                       input bit ivld, input logic [DW-1:0] idata,
                       input bit ordy, input bit clr);
    bit tpop, tpush, ovf_set, unf_set;
    IOWrite     = wr;
    IOOut       = wdata;
    IORead      = rd;
    DevInValid  = ivld;
    DevInData   = idata;
    DevOutReady = ordy;
    ClearFlags  = clr;

    exp_status = {m_unf, m_ovf, rx_q.size() != 0, tx_cnt == DEPTH};
    exp_ovalid = (tx_cnt != 0);
    exp_iready = (rx_q.size() != DEPTH);
    exp_ioin   = (rx_q.size() != 0) ? rx_q[0] : '0;

    tpop    = (tx_cnt != 0) && ordy;
    tpush   = wr && ((tx_cnt != DEPTH) || tpop);
    ovf_set = wr && !tpush;
    unf_set = rd && (rx_q.size() == 0);
    if (tpush) tx_exp.push_back(wdata);
    tx_cnt = tx_cnt + int'(tpush) - int'(tpop);

    last_rx_acc = ivld && (rx_q.size() != DEPTH);
    if (rd) begin
      if (rx_q.size() != 0) rx_exp.push_back(rx_q.pop_front());
      else                  rx_exp.push_back('0);
    end
    if (last_rx_acc) rx_q.push_back(idata);

    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_set ? 1'b1 : (clr ? 1'b0 : m_unf);

    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, '0, 0, 0);
  endtask

  // Assert reset mid-cycle, confirm outputs drop immediately, hold, release.
  task automatic hit_reset(input int n);
    Reset = 1'b1;
    IOWrite = 0; IORead = 0; DevInValid = 0; DevOutReady = 0; ClearFlags = 0;
    #1;
    check("rst_status", 32'(IOStatus), 32'h0);
    check("rst_out_valid", 32'(DevOutValid), 32'h0);
    check("rst_in_ready", 32'(DevInReady), 32'h1);
    check("rst_io_in", 32'(IOIn), 32'h0);
    tx_exp.delete(); rx_q.delete(); rx_exp.delete();
    tx_cnt = 0; m_ovf = 0; m_unf = 0;
    exp_status = 4'b0000; exp_ovalid = 1'b0; exp_iready = 1'b1; exp_ioin = '0;
    idle(n);
    Reset = 1'b0;
  endtask

  // Monitor: status every cycle, device transfers and CPU loads via scoreboard.
  always @(negedge CLK) begin
    check("status", 32'(IOStatus), 32'(exp_status));
    check("out_valid", 32'(DevOutValid), 32'(exp_ovalid));
    check("in_ready", 32'(DevInReady), 32'(exp_iready));
    check("io_in", 32'(IOIn), 32'(exp_ioin));
    if (DevOutValid) begin
      if (tx_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_data: got %h expected no word", DevOutData);
      end else begin
        check("tx_data", 32'(DevOutData), 32'(tx_exp[0]));
        if (DevOutReady) void'(tx_exp.pop_front());
      end
    end
    if (IORead && !Reset) begin
      if (rx_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_read: got %h expected no load", IOIn);
      end else begin
        check("rx_read", 32'(IOIn), 32'(rx_exp.pop_front()));
      end
    end
  end

  initial begin
    logic [DW-1:0] words [6];
    logic [DW-1:0] rx_word;
    int idx;

    // Reset state straight out of power-up.
    #2;
    check("init_status", 32'(IOStatus), 32'h0);
    check("init_out_valid", 32'(DevOutValid), 32'h0);
    check("init_in_ready", 32'(DevInReady), 32'h1);
    check("init_io_in", 32'(IOIn), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;

    // ClearFlags with nothing pending.
    drive(0, '0, 0, 0, '0, 0, 1);
    idle(1);

    // TX ordering with backpressure, then drain.
    drive(1, 16'h1111, 0, 0, '0, 0, 0);
    drive(1, 16'h2222, 0, 0, '0, 0, 0);
    drive(1, 16'h3333, 0, 0, '0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, '0, 1, 0);
    idle(2);

    // TX overflow: fifth word dropped and flag set.
    for (int i = 0; i < 5; i++) drive(1, 16'hA000 + 16'(i), 0, 0, '0, 0, 0);
    idle(1);
    drive(0, '0, 0, 0, '0, 0, 1);
    // Full FIFO with a pop in the same cycle accepts the store.
    drive(1, 16'hA005, 0, 0, '0, 1, 0);
    idle(1);
    // Overflow coinciding with ClearFlags: set wins.
    drive(1, 16'hA006, 0, 0, '0, 0, 1);
    idle(1);
    drive(0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 6; i++) drive(0, '0, 0, 0, '0, 1, 0);

    // RX flow and underflow.
    drive(0, '0, 0, 1, 16'h00AA, 0, 0);
    drive(0, '0, 0, 1, 16'h00BB, 0, 0);
    idle(1);
    drive(0, '0, 1, 0, '0, 0, 0);
    drive(0, '0, 1, 0, '0, 0, 0);
    drive(0, '0, 1, 0, '0, 0, 0);
    idle(1);
    drive(0, '0, 0, 0, '0, 0, 1);
    idle(1);

    // RX backpressure: six words offered, one pop lets exactly one more in.
    for (int i = 0; i < 6; i++) words[i] = 16'hB000 + 16'(i * 17);
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, '0, k == 6, idx < 6, words[idx < 6 ? idx : 5], 0, 0);
      if (last_rx_acc) idx++;
    end
    for (int i = 0; i < 6; i++) drive(0, '0, 1, 0, '0, 0, 0);
    drive(0, '0, 0, 0, '0, 0, 1);

    // Reset in the middle of traffic on both paths.
    for (int i = 0; i < 3; i++) drive(1, 16'hC000 + 16'(i), 0, 1, 16'hD000 + 16'(i), 0, 0);
    hit_reset(2);
    idle(2);

    // Randomized traffic with a device that holds its word until accepted.
    rx_word = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        hit_reset(2);
        rx_word = 16'($urandom);
      end
      drive($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, rx_word, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      if (last_rx_acc) rx_word = 16'($urandom);
    end

    // Drain both FIFOs; every queued word must have been delivered.
    for (int i = 0; i < 2 * DEPTH; i++) drive(0, '0, 1, 0, '0, 1, 0);
    idle(2);
    check("tx_all_delivered", 32'(tx_exp.size()), 32'h0);
    check("rx_all_read", 32'(rx_exp.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
